// File: rtl/sequence_detector.sv
// Moore detector for the serial pattern 1-0-1-1 with overlapping matches.
// detector_out is registered and pulses for one cycle in the MATCH state.
module sequence_detector (
    input  logic clock,
    input  logic reset,
    input  logic sequence_in,
    output logic detector_out
);

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    state_t state;

    // The output register is loaded with the decode of the next state, so it
    // always equals (state == S1011) without any combinational path from input.
    // An X/Z input fails the == 1'b1 test and follows the "0" branch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S0;
            detector_out <= 1'b0;
        end else begin
            detector_out <= 1'b0;
            case (state)
                S0: begin
                    if (sequence_in == 1'b1) state <= S1;
                    else                     state <= S0;
                end
                S1: begin
                    if (sequence_in == 1'b1) state <= S1;
                    else                     state <= S10;
                end
                S10: begin
                    if (sequence_in == 1'b1) state <= S101;
                    else                     state <= S0;
                end
                S101: begin
                    if (sequence_in == 1'b1) begin
                        state        <= S1011;
                        detector_out <= 1'b1;
                    end else begin
                        state <= S10;
                    end
                end
                // The trailing 1 of a match doubles as the first bit of the next one.
                S1011: begin
                    if (sequence_in == 1'b1) state <= S1;
                    else                     state <= S10;
                end
                default: begin
                    state <= S0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_detector.sv
// Bench for sequence_detector: directed plan sequences plus randomized traffic,
// checked against a sliding-window model of the last four sampled bits.
module tb_sequence_detector;

    logic clock;
    logic reset;
    logic sequence_in;
    logic detector_out;

    int   checks;
    int   errors;
    int   pulse_count;

    logic [3:0] model_window;
    int         model_bits;
    logic       model_expected;

    sequence_detector dut (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .detector_out (detector_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Called just after a falling edge: drive inputs, let one rising edge
    // sample them, update the model, then compare on the next falling edge.
    task automatic applyStimulus(input string tag, input logic bit_in, input logic rst_in);
        sequence_in = bit_in;
        reset       = rst_in;
        @(posedge clock);
        if (rst_in) begin
            model_window = 4'b0000;
            model_bits   = 0;
        end else begin
            model_window = {model_window[2:0], (bit_in === 1'b1)};
            model_bits++;
        end
        model_expected = (model_bits >= 4) && (model_window == 4'b1011);
        @(negedge clock);
        if (detector_out === 1'b1) pulse_count++;
        checkOutput(tag, {31'd0, detector_out}, {31'd0, model_expected});
    endtask

    task automatic runSequence(input string tag, input logic [15:0] pattern,
                               input int len, input int expected_pulses);
        applyStimulus({tag, "_rst"}, 1'b0, 1'b1);
        pulse_count = 0;
        for (int i = 0; i < len; i++) begin
            applyStimulus(tag, pattern[len - 1 - i], 1'b0);
        end
        checkOutput({tag, "_pulses"}, pulse_count, expected_pulses);
    endtask

    initial begin
        logic rnd_bit;
        logic rnd_rst;
        checks         = 0;
        errors         = 0;
        pulse_count    = 0;
        model_window   = 4'b0000;
        model_bits     = 0;
        model_expected = 1'b0;
        reset          = 1'b1;
        sequence_in    = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 3; i++) applyStimulus("reset_hold", 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus("after_reset", 1'b0, 1'b0);

        runSequence("basic",     16'b1011001100,  10, 1);
        runSequence("overlap",   16'b1011011,      7, 2);
        runSequence("near_miss", 16'b10011101010, 11, 0);
        runSequence("post_one",  16'b10111011,     8, 2);

        // Reset in the middle of "101" must discard that history.
        applyStimulus("midrst_pre", 1'b0, 1'b1);
        pulse_count = 0;
        applyStimulus("midrst", 1'b1, 1'b0);
        applyStimulus("midrst", 1'b0, 1'b0);
        applyStimulus("midrst", 1'b1, 1'b0);
        applyStimulus("midrst_reset", 1'b1, 1'b1);
        applyStimulus("midrst", 1'b1, 1'b0);
        checkOutput("midrst_no_early", pulse_count, 0);
        applyStimulus("midrst", 1'b0, 1'b0);
        applyStimulus("midrst", 1'b1, 1'b0);
        applyStimulus("midrst", 1'b1, 1'b0);
        checkOutput("midrst_pulses", pulse_count, 1);

        // X input must behave as 0: "101" then X then "1011" gives one match.
        runSequence("xin_pre", 16'b101, 3, 0);
        pulse_count = 0;
        applyStimulus("xin", 1'bx, 1'b0);
        applyStimulus("xin", 1'b1, 1'b0);
        applyStimulus("xin", 1'b1, 1'b0);
        checkOutput("xin_pulses", pulse_count, 1);

        for (int i = 0; i < 3000; i++) begin
            rnd_rst = ($urandom_range(0, 63) == 0);
            rnd_bit = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 49) == 0) rnd_bit = 1'bx;
            applyStimulus("random", rnd_bit, rnd_rst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequence_detector.md
Name: sequence_detector

Overview:
- Serial bit-stream pattern detector, Moore style. Detects the 4-bit sequence 1-0-1-1 on a 1-bit input sampled once per clock.
- Overlapping matches are allowed.
- Sits on a serial data path and flags each completed match with a one-cycle pulse for downstream control logic.

Parameters:
- None. The pattern 1011 and the length 4 are fixed.

Ports:
- clock  input  1  Single system clock. All state updates occur on the rising edge.
- reset  input  1  Synchronous, active-high reset. It is sampled on the rising edge of clock.
- sequence_in  input  1  Serial data bit. Sampled on every rising edge. The driver changes it away from the rising edge, for example on the falling edge.
- detector_out  output  1  Match flag. High while the FSM is in the MATCH state.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - reset=1 at a rising edge forces state S0 and detector_out=0 from that edge onward.
  - Reset has priority over sequence_in.
  - Asserting reset mid-sequence discards all partial-match history.
- State encoding: five states, S0 (nothing matched), S1 ("1"), S10 ("10"), S101 ("101"), S1011 (MATCH). Encoding is free, but the state must be held in a register.
- Transitions, evaluated on each rising edge with reset=0 (in=sequence_in):
  - S0: in=1 -> S1; in=0 -> S0
  - S1: in=1 -> S1; in=0 -> S10
  - S10: in=1 -> S101; in=0 -> S0
  - S101: in=1 -> S1011; in=0 -> S10
  - S1011: in=1 -> S1; in=0 -> S10 (overlap: the trailing "1" is reused as the first pattern bit)
- Output (Moore):
  - detector_out = 1 if and only if state == S1011. It depends only on state, never combinationally on sequence_in.
  - Latency: detector_out rises at the same rising edge that samples the 4th pattern bit. It stays high for exactly one clock period, until the next rising edge.
  - A 1 after a match (…10111) does not re-assert the output. A further "011" is required (…1011011 gives two pulses).
- Input values other than 1 (X or Z) are treated as 0.
- No illegal-state lockup: any unused encoding returns to S0 on the next edge.
- State update and output decode must be free of latches. The output must not glitch between edges.

Test Plan:
- Reset hold: reset=1 for 3 cycles with sequence_in=0. Expect detector_out=0 and state S0. Release reset on a falling edge, keep sequence_in=0 for 4 cycles. Expect detector_out to stay 0.
- Basic match: after reset, drive bits 1,0,1,1,0,0,1,1,0,0 one per cycle. Expect detector_out=1 only during the cycle following the edge that samples the 4th bit, and 0 everywhere else (exactly one pulse).
- Overlap: drive 1,0,1,1,0,1,1. Expect two one-cycle pulses, after bit 4 and after bit 7.
- Near misses: drive 1,0,0,1,1,1,0,1,0,1,0. Expect detector_out never asserted.
- Post-match 1: drive 1,0,1,1,1,0,1,1. Expect pulses only after bit 4 and bit 8, with none after bit 5.
- Mid-sequence reset: drive 1,0,1, then reset=1 for one edge, then 1. Expect no pulse. Then continue 0,1,1 and expect a pulse after the final 1 (the sequence restarts from the post-reset "1").
